// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit and its datapath:
// opcodes, funct codes, ALU ops, mux select codes and FSM state numbering.
package multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  function automatic logic is_known_opcode(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// Combinational R-type funct to ALU operation mapping; valid drops for
// funct codes the ALU does not implement (alu_op then defaults to ADD).
module alu_op_decoder
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                valid
);

  always_comb begin
    alu_op = ALU_OP_W'(ALU_ADD);
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
      FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
      FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
      FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
      FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Defining
// MULTICYCLE_MEM_WAIT_EN adds mem_ready and stalls FETCH/MEM_RD/MEM_WR on it.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_inst,
  output logic                inst_done,
  output logic [STATE_W-1:0]  dbg_state
);

  state_t               state;
  logic                 mem_rdy;
  logic [ALU_OP_W-1:0]  r_alu_op;
  logic                 r_funct_valid;
  logic                 unused_zero;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // The zero flag is combined with pc_write_cond in the datapath, not here.
  assign unused_zero = zero;

  alu_op_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_op_decoder (
    .funct (funct),
    .alu_op(r_alu_op),
    .valid (r_funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_rdy) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_R:         state <= S_R_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_I_EXEC;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_rdy) state <= S_MEM_WB;
        S_MEM_WR:   if (mem_rdy) state <= S_FETCH;
        S_R_EXEC:   state <= r_funct_valid ? S_R_WB : S_FETCH;
        S_I_EXEC:   state <= S_I_WB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Strobes decode the current state only (plus funct in R_EXEC and the
  // ready handshake); everything is held at 0 while reset is asserted.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_OP_W'(ALU_ADD);
    illegal_inst  = 1'b0;
    inst_done     = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_rdy;
          pc_write  = mem_rdy;
          alu_src_b = SRCB_FOUR;
        end
        S_DECODE: begin
          alu_src_b    = SRCB_IMM_SH;
          illegal_inst = !is_known_opcode(opcode);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          inst_done  = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          inst_done = mem_rdy;
        end
        S_R_EXEC: begin
          alu_src_a    = 1'b1;
          alu_src_b    = SRCB_B;
          alu_op       = r_alu_op;
          illegal_inst = !r_funct_valid;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          inst_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_B;
          alu_op        = ALU_OP_W'(ALU_SUB);
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          inst_done     = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
          inst_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_I_WB: begin
          reg_write = 1'b1;
          inst_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = rst ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control
// vectors are queued when an instruction is issued and compared as it runs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op;
  logic       illegal_inst, inst_done;
  logic [3:0] dbg_state;

  logic [23:0] exp_q[$];
  logic [23:0] exp_v, got_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready    (mem_ready),
`endif
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .illegal_inst (illegal_inst),
    .inst_done    (inst_done),
    .dbg_state    (dbg_state)
  );

  // Vector layout: pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
  // pc_source[1:0], alu_op[3:0], illegal_inst, inst_done, dbg_state[3:0].
  function automatic logic [23:0] ev(input int st, input logic [3:0] aop,
                                     input logic ill, input logic rdy);
    logic pcw, pcwc, iod, mr, mw, irw, rd, m2r, rw, sa, dn;
    logic [1:0] sb, ps;
    logic [3:0] op;
    {pcw, pcwc, iod, mr, mw, irw, rd, m2r, rw, sa, dn} = '0;
    sb = 2'd0;
    ps = 2'd0;
    op = 4'd0;
    case (st)
      0:  begin mr = 1'b1; irw = rdy; pcw = rdy; sb = 2'd1; end
      1:  sb = 2'd3;
      2:  begin sa = 1'b1; sb = 2'd2; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; dn = rdy; end
      6:  begin sa = 1'b1; op = aop; end
      7:  begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
      8:  begin sa = 1'b1; op = 4'd1; pcwc = 1'b1; ps = 2'd1; dn = 1'b1; end
      9:  begin pcw = 1'b1; ps = 2'd2; dn = 1'b1; end
      10: begin sa = 1'b1; sb = 2'd2; end
      11: begin rw = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    return {pcw, pcwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ps, op, ill, dn, 4'(st)};
  endfunction

  function automatic logic [23:0] observed();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
            alu_op, illegal_inst, inst_done, dbg_state};
  endfunction

  // Drives one instruction's IR fields and queues its cycle-by-cycle vectors.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] aop;
    logic       fv;
    opcode = op;
    funct  = fn;
    exp_q.push_back(ev(0, 4'd0, 1'b0, 1'b1));
    if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000})) begin
      exp_q.push_back(ev(1, 4'd0, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(ev(1, 4'd0, 1'b0, 1'b1));
      case (op)
        6'b100011: begin
          exp_q.push_back(ev(2, 4'd0, 1'b0, 1'b1));
          exp_q.push_back(ev(3, 4'd0, 1'b0, 1'b1));
          exp_q.push_back(ev(4, 4'd0, 1'b0, 1'b1));
        end
        6'b101011: begin
          exp_q.push_back(ev(2, 4'd0, 1'b0, 1'b1));
          exp_q.push_back(ev(5, 4'd0, 1'b0, 1'b1));
        end
        6'b000000: begin
          fv = 1'b1;
          case (fn)
            6'b100000: aop = 4'd0;
            6'b100010: aop = 4'd1;
            6'b100100: aop = 4'd2;
            6'b100101: aop = 4'd3;
            6'b101010: aop = 4'd4;
            default: begin aop = 4'd0; fv = 1'b0; end
          endcase
          exp_q.push_back(ev(6, aop, !fv, 1'b1));
          if (fv) exp_q.push_back(ev(7, 4'd0, 1'b0, 1'b1));
        end
        6'b000100: exp_q.push_back(ev(8, 4'd0, 1'b0, 1'b1));
        6'b000010: exp_q.push_back(ev(9, 4'd0, 1'b0, 1'b1));
        default: begin
          exp_q.push_back(ev(10, 4'd0, 1'b0, 1'b1));
          exp_q.push_back(ev(11, 4'd0, 1'b0, 1'b1));
        end
      endcase
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    opcode = 6'b000010;
    funct  = 6'd0;
    zero   = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(24'h0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = observed();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold: got %h expected %h at %0t", got_v, exp_v, $time);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    push_instr(6'b000010, 6'd0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = observed();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_release: got %h expected %h at %0t", got_v, exp_v, $time);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_ops();
    push_instr(6'b100011, 6'd0);
    push_instr(6'b101011, 6'd0);
    opcode = 6'b100011;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = observed();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL mem_ops: got %h expected %h at %0t", got_v, exp_v, $time);
      end
      @(posedge clk); #1;
      if (exp_q.size() == 4) opcode = 6'b101011;
    end
  endtask

  task automatic test_r_type();
    logic [5:0] fns[6];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    for (int k = 0; k < 10; k++) begin
      push_instr(6'b000000, (k < 6) ? fns[k] : fns[$urandom_range(0, 5)]);
      while (exp_q.size() != 0) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        got_v = observed();
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL r_type funct=%b: got %h expected %h at %0t", funct, got_v, exp_v, $time);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch_jump_addi();
    logic [5:0] ops[3];
    ops = '{6'b000100, 6'b000010, 6'b001000};
    for (int k = 0; k < 3; k++) begin
      zero = k[0];
      push_instr(ops[k], 6'($urandom_range(0, 63)));
      while (exp_q.size() != 0) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        got_v = observed();
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL branch_jump_addi op=%b: got %h expected %h at %0t", opcode, got_v, exp_v, $time);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal_opcode();
    logic [5:0] op;
    for (int k = 0; k < 6; k++) begin
      op = (k == 0) ? 6'b111111 : 6'($urandom_range(0, 63));
      while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000})
        op = 6'($urandom_range(0, 63));
      push_instr(op, 6'd0);
      while (exp_q.size() != 0) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        got_v = observed();
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL illegal_opcode op=%b: got %h expected %h at %0t", op, got_v, exp_v, $time);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'b101011;
    exp_q.push_back(ev(0, 4'd0, 1'b0, 1'b1));
    exp_q.push_back(ev(1, 4'd0, 1'b0, 1'b1));
    exp_q.push_back(24'h0);
    while (exp_q.size() != 0) begin
      if (exp_q.size() == 1) rst = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = observed();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid: got %h expected %h at %0t", got_v, exp_v, $time);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    push_instr(6'b000010, 6'd0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = observed();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_recover: got %h expected %h at %0t", got_v, exp_v, $time);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111110};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int k = 0; k < 16; k++) begin
      push_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 5)]);
      while (exp_q.size() != 0) begin
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_v = exp_q.pop_front();
        got_v = observed();
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL back_to_back op=%b funct=%b: got %h expected %h at %0t", opcode, funct, got_v, exp_v, $time);
        end
        @(posedge clk); #1;
      end
    end
  endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
  task automatic test_mem_wait();
    int   st[16];
    logic rd[16];
    st = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0, 1, 2, 5, 5, 5};
    rd = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1};
    opcode = 6'b100011;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) opcode = 6'b101011;
      mem_ready = rd[i];
      exp_q.push_back(ev(st[i], 4'd0, 1'b0, rd[i]));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = observed();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL mem_wait cycle %0d: got %h expected %h at %0t", i, got_v, exp_v, $time);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
  endtask
`endif

  initial begin
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    test_reset();
    test_mem_ops();
    test_r_type();
    test_branch_jump_addi();
    test_illegal_opcode();
    test_reset_mid();
    test_back_to_back();
`ifdef MULTICYCLE_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut/MDR registers, one ALU.
- Replaces the single-cycle combinational control unit. The datapath is otherwise unchanged except for the added latches and muxes.
- Decodes opcode/funct held in the IR and emits per-cycle control strobes.
- Illegal opcodes are flagged and skipped.

Parameters:
- ALU_OP_W, 4, width of alu_op (matches the ALU opcode field in defines).
- STATE_W, 4, width of the state register and the dbg_state port.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low.
- opcode  in  6  IR[31:26]; stable from the end of FETCH until the next FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory done (only with MEM_WAIT_EN).
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- pc_source  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump address.
- alu_op  out  ALU_OP_W  ALU operation.
- illegal_inst  out  1  one-cycle pulse on an unknown opcode or funct.
- inst_done  out  1  one-cycle pulse in the final cycle of each instruction.
- dbg_state  out  STATE_W  current state.

Behaviour:
- Reset: while rst==0 at a clock edge, state is set to FETCH. All outputs are forced to 0 while rst==0 (gated, not merely the FETCH decode). The first fetch happens in the first cycle after rst goes high. Reset mid-instruction abandons the instruction; no further reg_write or mem_write is issued.
- Encodings:
  - Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
  - Funct: ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
  - ALU ops: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- States and outputs (any output not listed is 0):
  - FETCH(0): mem_read, ir_write, pc_write, alu_src_b=1, alu_op=ADD → DECODE.
  - DECODE(1): alu_src_b=3, alu_op=ADD. Next state by opcode: LW/SW → MEM_ADDR; R → R_EXEC; BEQ → BRANCH; J → JUMP; ADDI → I_EXEC; other → FETCH with illegal_inst=1.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=2, ADD → MEM_RD if LW, MEM_WR if SW.
  - MEM_RD(3): mem_read, i_or_d → MEM_WB.
  - MEM_WB(4): reg_write, mem_to_reg, inst_done → FETCH.
  - MEM_WR(5): mem_write, i_or_d, inst_done → FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=0, alu_op from funct → R_WB. Unknown funct: alu_op=ADD, illegal_inst=1 → FETCH; no write-back.
  - R_WB(7): reg_write, reg_dst, inst_done → FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond, pc_source=1, inst_done → FETCH.
  - JUMP(9): pc_write, pc_source=2, inst_done → FETCH.
  - I_EXEC(10): alu_src_a=1, alu_src_b=2, ADD → I_WB.
  - I_WB(11): reg_write, inst_done → FETCH.
  - Unused encodings 12–15 → FETCH, all outputs 0.
- Latency in cycles: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Outputs are a pure function of state (plus funct in R_EXEC). inst_done and illegal_inst are never both high.

Optional Feature:
- MULTICYCLE_MEM_WAIT_EN defined:
  - FETCH, MEM_RD and MEM_WR hold until mem_ready==1.
  - mem_read/mem_write stay asserted while waiting.
  - ir_write, pc_write and (in MEM_WR) inst_done assert only in the cycle mem_ready==1.
  - The state advances on that edge.
- Undefined: the mem_ready port is absent; memory is treated as single-cycle (ready=1).

Decomposition:
- Shared package/defines holds: opcode, funct and ALU-op constants, state encodings, and the alu_src_b/pc_source select codes. These are shared with the datapath top.
- One natural sub-module, alu_op_decoder: combinational funct→alu_op mapping with a valid flag.

Test Plan:
- Reset: rst=0 for 3 cycles → all outputs 0, dbg_state=0. Release → cycle 1 has mem_read=ir_write=pc_write=1.
- LW (opcode 100011) → states 0,1,2,3,4; reg_write=mem_to_reg=1 only in cycle 5; inst_done exactly once.
- R-type with funct 101010 → alu_op=4 in R_EXEC, reg_write+reg_dst in cycle 4. Funct 111111 → illegal_inst in cycle 3, back to FETCH, no reg_write.
- BEQ → pc_write_cond=1, pc_source=1, alu_op=1 in cycle 3. J → pc_write=1, pc_source=2 in cycle 3. Opcode 111111 → illegal_inst in cycle 2.
- SW → mem_write=i_or_d=1 in cycle 4. Reset asserted in MEM_ADDR → next state FETCH, no mem_write observed.
- With MULTICYCLE_MEM_WAIT_EN: mem_ready low for 3 cycles in FETCH → state stays 0, ir_write=0; ir_write=pc_write=1 only in the ready cycle; LW total latency = 5 + stall cycles.
